// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: data/MDU stall detection, operand forward selects, MDU busy countdown.
// Stall and forward outputs are combinational in the same cycle; no backpressure, holds are requests to the pipeline.
module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_addr_ID,
    input  logic [4:0]  rt_addr_ID,
    input  logic [3:0]  rs_use_ID,
    input  logic [3:0]  rt_use_ID,
    input  logic        md_ID,
    input  logic [4:0]  dst_addr_EX,
    input  logic [3:0]  dst_save_EX,
    input  logic [4:0]  dst_addr_MEM,
    input  logic [3:0]  dst_save_MEM,
    input  logic [4:0]  dst_addr_WB,
    input  logic        md_start_EX,
    input  logic        md_is_div_EX,
    output logic        stall,
    output logic        PC_enable,
    output logic        ID_enable,
    output logic        EX_flush,
    output logic [1:0]  fwd_rs_ID,
    output logic [1:0]  fwd_rt_ID,
    output logic        md_busy,
    output logic [15:0] stall_count
);

    localparam logic [1:0]  FWD_GRF     = 2'd0;
    localparam logic [1:0]  FWD_EX      = 2'd1;
    localparam logic [1:0]  FWD_MEM     = 2'd2;
    localparam logic [1:0]  FWD_WB      = 2'd3;
    localparam logic [3:0]  MD_MULT_CYC = 4'd5;
    localparam logic [3:0]  MD_DIV_CYC  = 4'd10;
    localparam logic [15:0] CNT_MAX     = 16'hFFFF;

    logic [3:0]  md_cnt_q, md_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic rs_hit_ex, rs_hit_mem, rs_hit_wb;
    logic rt_hit_ex, rt_hit_mem, rt_hit_wb;
    logic data_stall, md_stall;

    // Register $0 is hardwired, so a zero destination never produces a hazard.
    assign rs_hit_ex  = (rs_addr_ID == dst_addr_EX)  && (dst_addr_EX  != 5'd0);
    assign rs_hit_mem = (rs_addr_ID == dst_addr_MEM) && (dst_addr_MEM != 5'd0);
    assign rs_hit_wb  = (rs_addr_ID == dst_addr_WB)  && (dst_addr_WB  != 5'd0);
    assign rt_hit_ex  = (rt_addr_ID == dst_addr_EX)  && (dst_addr_EX  != 5'd0);
    assign rt_hit_mem = (rt_addr_ID == dst_addr_MEM) && (dst_addr_MEM != 5'd0);
    assign rt_hit_wb  = (rt_addr_ID == dst_addr_WB)  && (dst_addr_WB  != 5'd0);

    assign data_stall = (rs_hit_ex  && (rs_use_ID < dst_save_EX))
                      | (rs_hit_mem && (rs_use_ID < dst_save_MEM))
                      | (rt_hit_ex  && (rt_use_ID < dst_save_EX))
                      | (rt_hit_mem && (rt_use_ID < dst_save_MEM));

    assign md_busy   = (md_cnt_q != 4'd0);
    assign md_stall  = md_ID && (md_busy || md_start_EX);

    assign stall     = data_stall || md_stall;
    assign PC_enable = ~stall;
    assign ID_enable = ~stall;
    assign EX_flush  = stall;

    // The nearest matching stage owns the operand; if its value is not ready yet,
    // older copies in farther stages are stale and must not be forwarded.
    always_comb begin
        fwd_rs_ID = FWD_GRF;
        if (rs_hit_ex) begin
            if (dst_save_EX == 4'd0) fwd_rs_ID = FWD_EX;
        end else if (rs_hit_mem) begin
            if (dst_save_MEM == 4'd0) fwd_rs_ID = FWD_MEM;
        end else if (rs_hit_wb) begin
            fwd_rs_ID = FWD_WB;
        end
    end

    always_comb begin
        fwd_rt_ID = FWD_GRF;
        if (rt_hit_ex) begin
            if (dst_save_EX == 4'd0) fwd_rt_ID = FWD_EX;
        end else if (rt_hit_mem) begin
            if (dst_save_MEM == 4'd0) fwd_rt_ID = FWD_MEM;
        end else if (rt_hit_wb) begin
            fwd_rt_ID = FWD_WB;
        end
    end

    // A start request while the MDU is already counting is dropped.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start_EX && !md_busy) begin
            md_cnt_d = md_is_div_EX ? MD_DIV_CYC : MD_MULT_CYC;
        end else if (md_cnt_q != 4'd0) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt_q    <= 4'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboarded bench for hazard_ctrl: driver pushes reference-model expectations, monitor checks at negedge.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_addr_ID, rt_addr_ID, dst_addr_EX, dst_addr_MEM, dst_addr_WB;
    logic [3:0]  rs_use_ID, rt_use_ID, dst_save_EX, dst_save_MEM;
    logic        md_ID, md_start_EX, md_is_div_EX;
    logic        stall, PC_enable, ID_enable, EX_flush, md_busy;
    logic [1:0]  fwd_rs_ID, fwd_rt_ID;
    logic [15:0] stall_count;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .rs_addr_ID(rs_addr_ID), .rt_addr_ID(rt_addr_ID),
        .rs_use_ID(rs_use_ID), .rt_use_ID(rt_use_ID), .md_ID(md_ID),
        .dst_addr_EX(dst_addr_EX), .dst_save_EX(dst_save_EX),
        .dst_addr_MEM(dst_addr_MEM), .dst_save_MEM(dst_save_MEM),
        .dst_addr_WB(dst_addr_WB),
        .md_start_EX(md_start_EX), .md_is_div_EX(md_is_div_EX),
        .stall(stall), .PC_enable(PC_enable), .ID_enable(ID_enable), .EX_flush(EX_flush),
        .fwd_rs_ID(fwd_rs_ID), .fwd_rt_ID(fwd_rt_ID),
        .md_busy(md_busy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       stall;
        int       frs;
        int       frt;
        bit       busy;
        int       cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference state: MDU cycles still to run and total stalled cycles.
    int   busy_left = 0;
    int   stall_total = 0;
    bit   cur_stall;

    function automatic int ref_fwd(input logic [4:0] a);
        logic [4:0] d [3];
        logic [3:0] s [3];
        d = '{dst_addr_EX, dst_addr_MEM, dst_addr_WB};
        s = '{dst_save_EX, dst_save_MEM, 4'd0};
        for (int i = 0; i < 3; i++)
            if (d[i] != 5'd0 && a == d[i]) return (s[i] == 4'd0) ? i + 1 : 0;
        return 0;
    endfunction

    function automatic bit ref_data_stall();
        logic [4:0] d [2];
        int         s [2];
        logic [4:0] a [2];
        int         u [2];
        d = '{dst_addr_EX, dst_addr_MEM};
        s = '{int'(dst_save_EX), int'(dst_save_MEM)};
        a = '{rs_addr_ID, rt_addr_ID};
        u = '{int'(rs_use_ID), int'(rt_use_ID)};
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                if (d[i] != 5'd0 && a[j] == d[i] && u[j] < s[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step();
        exp_t e;
        if (reset) begin
            busy_left   = 0;
            stall_total = 0;
        end
        e.busy  = (busy_left > 0);
        e.stall = ref_data_stall() || (md_ID && (e.busy || md_start_EX));
        e.frs   = ref_fwd(rs_addr_ID);
        e.frt   = ref_fwd(rt_addr_ID);
        e.cnt   = stall_total;
        cur_stall = e.stall;
        exp_q.push_back(e);
        @(posedge clk);
        if (reset) begin
            busy_left   = 0;
            stall_total = 0;
        end else begin
            if (cur_stall && stall_total < 65535) stall_total++;
            if (md_start_EX && busy_left == 0) busy_left = md_is_div_EX ? 10 : 5;
            else if (busy_left > 0) busy_left--;
        end
        #1;
    endtask

    task automatic quiet();
        rs_addr_ID = 0; rt_addr_ID = 0; rs_use_ID = 4; rt_use_ID = 4; md_ID = 0;
        dst_addr_EX = 0; dst_save_EX = 0; dst_addr_MEM = 0; dst_save_MEM = 0;
        dst_addr_WB = 0; md_start_EX = 0; md_is_div_EX = 0;
    endtask

    task automatic check(input string name, input int got, input int want);
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                check("stall",       int'(stall),       int'(e.stall));
                check("PC_enable",   int'(PC_enable),   int'(!e.stall));
                check("ID_enable",   int'(ID_enable),   int'(!e.stall));
                check("EX_flush",    int'(EX_flush),    int'(e.stall));
                check("fwd_rs_ID",   int'(fwd_rs_ID),   e.frs);
                check("fwd_rt_ID",   int'(fwd_rt_ID),   e.frt);
                check("md_busy",     int'(md_busy),     int'(e.busy));
                check("stall_count", int'(stall_count), e.cnt);
            end
        end
    end

    initial begin
        int guard;
        quiet();
        reset = 1'b1;
        @(posedge clk); #1;
        step(); step();
        reset = 1'b0;

        // Load-use on rs from EX.
        rs_addr_ID = 5; rs_use_ID = 0; dst_addr_EX = 5; dst_save_EX = 1;
        step();
        // MEM forward with no EX match.
        quiet(); rs_addr_ID = 5; rs_use_ID = 0; dst_addr_MEM = 5; dst_save_MEM = 0; dst_addr_EX = 7;
        step();
        // $0 producer never stalls or forwards.
        quiet(); rt_addr_ID = 0; rt_use_ID = 0; dst_addr_EX = 0; dst_save_EX = 2;
        step();
        // Nearer pending EX blocks a ready MEM copy.
        quiet(); rt_addr_ID = 9; rt_use_ID = 3; dst_addr_EX = 9; dst_save_EX = 2;
        dst_addr_MEM = 9; dst_addr_WB = 9;
        step();

        // Divide: 11 stalled cycles including the start cycle.
        quiet(); reset = 1'b1; step(); reset = 1'b0;
        md_ID = 1; md_start_EX = 1; md_is_div_EX = 1;
        step();
        md_start_EX = 0; md_is_div_EX = 0;
        repeat (10) step();
        md_ID = 0;
        repeat (2) step();

        // Reset while the divide counter reads 4.
        md_ID = 1; md_start_EX = 1; md_is_div_EX = 1;
        step();
        md_start_EX = 0;
        guard = 0;
        while (busy_left != 4 && guard < 20) begin
            step();
            guard++;
        end
        check("reach_cnt4", busy_left, 4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (3) step();

        // Random traffic with occasional reset.
        for (int n = 0; n < 3000; n++) begin
            rs_addr_ID   = 5'($urandom_range(0, 3));
            rt_addr_ID   = 5'($urandom_range(0, 3));
            rs_use_ID    = 4'($urandom_range(0, 4));
            rt_use_ID    = 4'($urandom_range(0, 4));
            dst_addr_EX  = 5'($urandom_range(0, 3));
            dst_addr_MEM = 5'($urandom_range(0, 3));
            dst_addr_WB  = 5'($urandom_range(0, 3));
            dst_save_EX  = 4'($urandom_range(0, 3));
            dst_save_MEM = 4'($urandom_range(0, 3));
            md_ID        = ($urandom_range(0, 2) == 0);
            md_start_EX  = ($urandom_range(0, 5) == 0);
            md_is_div_EX = 1'($urandom_range(0, 1));
            reset        = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;

        // Saturation of the stall counter.
        quiet(); rs_addr_ID = 5; rs_use_ID = 0; dst_addr_EX = 5; dst_save_EX = 1;
        repeat (70000) step();
        check("sat_model", stall_total, 65535);
        repeat (5) step();
        quiet();
        step();

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
